fc_layer_scheduler: RTL and testbench
=====================================

FC_LAYER_SCHEDULER -- requirements
Module: fc_layer_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH, 22, signed activation width
  VEC_LEN, 225, flattened vector length
  NUM_OUT, 10, output neurons
  WEIGHT_WIDTH, 8, signed weight width
  FRAC_BITS, 6, weight fractional bits
  ACC_WIDTH, 38, accumulator width
  WADDR_WIDTH, 12, weight address width (ceil(log2(VEC_LEN*NUM_OUT)))
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  start_signal  in  1  one-cycle pulse that arms a layer run
  vec_valid  in  1  flatten buffer result_valid; vector is stable while high
  vec_in  in  DATA_WIDTH x VEC_LEN  signed flattened vector [0:VEC_LEN-1]
  weight_rd_en  out  1  weight ROM read strobe
  weight_addr  out  WADDR_WIDTH  weight ROM address
  weight_data  in  WEIGHT_WIDTH  signed weight, valid one cycle after weight_rd_en
  out_valid  out  1  one-cycle pulse, neuron result present
  out_idx  out  4  neuron index 0..NUM_OUT-1
  out_data  out  DATA_WIDTH  signed saturated neuron result
  busy  out  1  high in every state except IDLE
  done_signal  out  1  one-cycle pulse after the last neuron

Function
REQ-003 The FSM SHALL have the states IDLE, WAIT_VEC, RUN, DRAIN, EMIT, and DONE.
REQ-004 IDLE->WAIT_VEC on start_signal; otherwise remain; vec_valid in IDLE ignored.
REQ-005 WAIT_VEC: on vec_valid, capture all VEC_LEN elements into an internal register, clear acc, neuron=0, j=0, go RUN.
REQ-006 RUN: each cycle assert weight_rd_en, weight_addr = neuron*VEC_LEN + j, j increments; after j=VEC_LEN-1 issued go DRAIN.
REQ-007 One cycle after each read, acc += vec_reg[j_delayed] * weight_data (full-precision signed product, sign-extended to ACC_WIDTH).
REQ-008 DRAIN: one cycle, no read; the final product is accumulated.
REQ-009 EMIT: out_valid=1 for one cycle, out_idx=neuron, out_data=sat(acc >>> FRAC_BITS); acc cleared; if neuron=NUM_OUT-1 go DONE, else neuron++, j=0, go RUN.
REQ-010 Saturation: results above 2^(DATA_WIDTH-1)-1 clamp to 2097151; results below -2^(DATA_WIDTH-1) clamp to -2097152; the shift is an arithmetic shift that truncates toward negative infinity.
REQ-011 DONE: done_signal=1 for one cycle, then IDLE.
REQ-012 Latency SHALL be VEC_LEN+2 = 227 cycles per neuron from RUN entry to the out_valid pulse; total 2270 cycles from vec capture to the last out_valid; done_signal on the following cycle.
REQ-013 start_signal while busy SHALL be ignored; vec_valid outside WAIT_VEC ignored; vec_in changes after capture have no effect.
REQ-014 start_signal and vec_valid in the same IDLE cycle SHALL only enter WAIT_VEC; capture occurs on the next vec_valid-high cycle.
REQ-015 weight_rd_en SHALL be 0 outside RUN; weight_addr holds its last value when idle.

Reset
REQ-016 rst low SHALL asynchronously force IDLE and clear acc, j, neuron, vec_reg, and all outputs (weight_rd_en, weight_addr, out_valid, out_idx, out_data, busy, done_signal = 0).
REQ-017 Reset mid-run SHALL abort with no out_valid or done_signal; the next run requires a new start_signal.

Structure
REQ-018 Package npu_pkg SHALL hold DATA_WIDTH, VEC_LEN, NUM_OUT, WEIGHT_WIDTH, FRAC_BITS, ACC_WIDTH, and the FSM state enum typedef.
REQ-019 One sub-module SHALL be fc_mac_unit: registered multiply-accumulate with clear, enable, and the saturating shift output; the FSM and counters stay in the top.

Verification
REQ-020 All vec=1.0 (64), all weights=64: out_data = 225*64 = 14400 for each of 10 neurons; out_idx 0..9; done one cycle after idx 9.
REQ-021 vec[i]=i, weight(n,i)=n+1: out_data = (n+1)*25200/64 truncated, e.g. n=0 -> 393.
REQ-022 vec=2097151, weight=127: out_data = 2097151 (saturated); weight=-128 -> out_data = -2097152.
REQ-023 start_signal pulsed mid-RUN: no restart; cycle counts unchanged (227 per neuron); exactly 10 out_valid pulses.
REQ-024 rst low at neuron 4, j=100: all outputs 0 next edge; no further out_valid; a new start plus vec yields a full correct run.
REQ-025 Weight address check: addresses seen are 0..2249 contiguous; weight_rd_en high exactly 2250 cycles per run.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared constants and types for the fully-connected layer scheduler.
// Holds the default datapath geometry and the scheduler FSM state type.
package npu_pkg;

  localparam int unsigned DATA_WIDTH   = 22;   // signed activation width
  localparam int unsigned VEC_LEN      = 225;  // flattened vector length
  localparam int unsigned NUM_OUT      = 10;   // output neurons
  localparam int unsigned WEIGHT_WIDTH = 8;    // signed weight width
  localparam int unsigned FRAC_BITS    = 6;    // weight fractional bits
  localparam int unsigned ACC_WIDTH    = 38;   // accumulator width
  localparam int unsigned WADDR_WIDTH  = 12;   // weight ROM address width

  typedef enum logic [2:0] {
    StIdle,
    StWaitVec,
    StRun,
    StDrain,
    StEmit,
    StDone
  } fc_state_e;

endpackage

// File: rtl/fc_layer_scheduler_if.sv
// Bundle of the scheduler's control, vector, weight-ROM and result signals.
//   slave  : scheduler side (takes start/vector/weights, drives ROM reads and results)
//   master : environment side (drives start/vector/weights, observes results)
interface fc_layer_scheduler_if #(
  parameter int unsigned DATA_WIDTH   = npu_pkg::DATA_WIDTH,
  parameter int unsigned VEC_LEN      = npu_pkg::VEC_LEN,
  parameter int unsigned WEIGHT_WIDTH = npu_pkg::WEIGHT_WIDTH,
  parameter int unsigned WADDR_WIDTH  = npu_pkg::WADDR_WIDTH
);

  logic                                start_signal;
  logic                                vec_valid;
  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]  vec_in;        // element i is vec_in[i]
  logic                                weight_rd_en;
  logic [WADDR_WIDTH-1:0]              weight_addr;
  logic signed [WEIGHT_WIDTH-1:0]      weight_data;   // valid one cycle after weight_rd_en
  logic                                out_valid;
  logic [3:0]                          out_idx;
  logic signed [DATA_WIDTH-1:0]        out_data;
  logic                                busy;
  logic                                done_signal;

  modport slave (
    input  start_signal, vec_valid, vec_in, weight_data,
    output weight_rd_en, weight_addr, out_valid, out_idx, out_data, busy, done_signal
  );

  modport master (
    output start_signal, vec_valid, vec_in, weight_data,
    input  weight_rd_en, weight_addr, out_valid, out_idx, out_data, busy, done_signal
  );

endinterface

// File: rtl/fc_mac_unit.sv
// Registered signed multiply-accumulate with a saturating fixed-point output.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : zero the accumulator (wins over en_i)
//   en_i          : add a_i * b_i into the accumulator
//   a_i, b_i      : signed activation and weight
//   sat_o         : acc >>> FracBits, clamped to the signed DataW range
module fc_mac_unit #(
  parameter int unsigned DataW    = 22,
  parameter int unsigned WeightW  = 8,
  parameter int unsigned AccW     = 38,
  parameter int unsigned FracBits = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic signed [DataW-1:0]   a_i,
  input  logic signed [WeightW-1:0] b_i,
  output logic signed [DataW-1:0]   sat_o
);

  localparam int unsigned ProdW = DataW + WeightW;

  localparam logic signed [AccW-1:0] SatMax =
    {{(AccW - DataW + 1){1'b0}}, {(DataW - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin =
    {{(AccW - DataW + 1){1'b1}}, {(DataW - 1){1'b0}}};

  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  prod_ext;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic signed [AccW-1:0]  shifted;

  // Operands are widened first so the product keeps full precision.
  assign prod     = ProdW'(a_i) * ProdW'(b_i);
  assign prod_ext = AccW'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Arithmetic shift floors toward negative infinity.
  assign shifted = acc_q >>> FracBits;

  always_comb begin
    sat_o = shifted[DataW-1:0];
    if (shifted > SatMax) begin
      sat_o = SatMax[DataW-1:0];
    end else if (shifted < SatMin) begin
      sat_o = SatMin[DataW-1:0];
    end
  end

endmodule

// File: rtl/fc_layer_scheduler.sv
// Sequences one fully-connected layer: captures a flattened vector, streams the
// weight ROM row by row, accumulates each neuron in fc_mac_unit and emits the
// saturated results one per neuron.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   bus_io : start/vector inputs, weight ROM read port, result and status outputs
module fc_layer_scheduler #(
  parameter int unsigned DATA_WIDTH   = npu_pkg::DATA_WIDTH,
  parameter int unsigned VEC_LEN      = npu_pkg::VEC_LEN,
  parameter int unsigned NUM_OUT      = npu_pkg::NUM_OUT,
  parameter int unsigned WEIGHT_WIDTH = npu_pkg::WEIGHT_WIDTH,
  parameter int unsigned FRAC_BITS    = npu_pkg::FRAC_BITS,
  parameter int unsigned ACC_WIDTH    = npu_pkg::ACC_WIDTH,
  parameter int unsigned WADDR_WIDTH  = npu_pkg::WADDR_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  fc_layer_scheduler_if.slave bus_io
);

  localparam int unsigned JW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [JW-1:0] JLast = JW'(VEC_LEN - 1);
  localparam logic [3:0]    NLast = 4'(NUM_OUT - 1);

  npu_pkg::fc_state_e state_q, state_d;

  logic [JW-1:0]                      j_q, j_d;
  logic [JW-1:0]                      jd_q;      // element index of the read in flight
  logic [3:0]                         neuron_q, neuron_d;
  logic [WADDR_WIDTH-1:0]             addr_q, addr_d;
  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] vec_q;
  logic                               rd_en;
  logic                               rd_q;      // weight_data valid this cycle
  logic                               capture;
  logic                               mac_clr;
  logic signed [DATA_WIDTH-1:0]       mac_a;
  logic signed [DATA_WIDTH-1:0]       mac_out;

  // Addresses run contiguously (neuron*VEC_LEN + j), so a single incrementing
  // counter replaces the multiply; it holds its last value once the run stops.
  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    neuron_d = neuron_q;
    addr_d   = addr_q;
    capture  = 1'b0;
    mac_clr  = 1'b0;
    unique case (state_q)
      npu_pkg::StIdle: begin
        if (bus_io.start_signal) begin
          state_d = npu_pkg::StWaitVec;
        end
      end
      npu_pkg::StWaitVec: begin
        if (bus_io.vec_valid) begin
          capture  = 1'b1;
          mac_clr  = 1'b1;
          j_d      = '0;
          neuron_d = '0;
          addr_d   = '0;
          state_d  = npu_pkg::StRun;
        end
      end
      npu_pkg::StRun: begin
        if (j_q == JLast) begin
          state_d = npu_pkg::StDrain;
        end else begin
          j_d    = j_q + JW'(1);
          addr_d = addr_q + WADDR_WIDTH'(1);
        end
      end
      npu_pkg::StDrain: begin
        state_d = npu_pkg::StEmit;
      end
      npu_pkg::StEmit: begin
        mac_clr = 1'b1;
        if (neuron_q == NLast) begin
          state_d = npu_pkg::StDone;
        end else begin
          neuron_d = neuron_q + 4'd1;
          j_d      = '0;
          addr_d   = addr_q + WADDR_WIDTH'(1);
          state_d  = npu_pkg::StRun;
        end
      end
      npu_pkg::StDone: begin
        state_d = npu_pkg::StIdle;
      end
      default: begin
        state_d = npu_pkg::StIdle;
      end
    endcase
  end

  assign rd_en = (state_q == npu_pkg::StRun);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= npu_pkg::StIdle;
      j_q      <= '0;
      jd_q     <= '0;
      neuron_q <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      jd_q     <= j_q;
      neuron_q <= neuron_d;
      addr_q   <= addr_d;
      rd_q     <= rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_q <= '0;
    end else if (capture) begin
      vec_q <= bus_io.vec_in;
    end
  end

  assign mac_a = vec_q[jd_q];

  fc_mac_unit #(
    .DataW    (DATA_WIDTH),
    .WeightW  (WEIGHT_WIDTH),
    .AccW     (ACC_WIDTH),
    .FracBits (FRAC_BITS)
  ) u_mac (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (mac_clr),
    .en_i   (rd_q),
    .a_i    (mac_a),
    .b_i    (bus_io.weight_data),
    .sat_o  (mac_out)
  );

  // Outputs decode directly from registered state, so reset zeroes them at once.
  assign bus_io.weight_rd_en = rd_en;
  assign bus_io.weight_addr  = addr_q;
  assign bus_io.out_valid    = (state_q == npu_pkg::StEmit);
  assign bus_io.out_idx      = neuron_q;
  assign bus_io.out_data     = mac_out;
  assign bus_io.busy         = (state_q != npu_pkg::StIdle);
  assign bus_io.done_signal  = (state_q == npu_pkg::StDone);

endmodule

// File: tb/tb_fc_layer_scheduler.sv
module tb_fc_layer_scheduler;
  import npu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fc_layer_scheduler_if bus ();

  fc_layer_scheduler dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Weight ROM model: registered read, one-cycle latency.
  bit w_ramp = 1'b0;
  int w_val  = 0;
  always @(posedge clk) begin
    if (bus.weight_rd_en) begin
      if (w_ramp) bus.weight_data <= WEIGHT_WIDTH'(int'(bus.weight_addr) / VEC_LEN + 1);
      else        bus.weight_data <= WEIGHT_WIDTH'(w_val);
    end
  end

  // Monitor.
  int cyc = 0;
  int ov_cnt = 0, done_cnt = 0, rd_cnt = 0, addr_err = 0, exp_addr = 0, done_cyc = 0;
  int ov_idx [256];
  int ov_data[256];
  int ov_cyc [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!bus.busy) exp_addr <= 0;
    if (bus.weight_rd_en) begin
      if (int'(bus.weight_addr) != exp_addr) addr_err <= addr_err + 1;
      exp_addr <= int'(bus.weight_addr) + 1;
      rd_cnt   <= rd_cnt + 1;
    end
    if (bus.out_valid && ov_cnt < 256) begin
      ov_idx[ov_cnt]  <= int'(bus.out_idx);
      ov_data[ov_cnt] <= int'(bus.out_data);
      ov_cyc[ov_cnt]  <= cyc;
      ov_cnt          <= ov_cnt + 1;
    end
    if (bus.done_signal) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    bit    vramp;
    int    vval;
    bit    wramp;
    int    wval;
    bit    eramp;
    int    econst;
  } vec_t;

  int ramp_exp[10] = '{393, 787, 1181, 1575, 1968, 2362, 2756, 3150, 3543, 3937};

  int cap_cyc, ov_base, rd_base, done_base, err_base;

  task automatic set_vec(input bit vramp, input int vval);
    for (int i = 0; i < int'(VEC_LEN); i++) begin
      bus.vec_in[i] = vramp ? DATA_WIDTH'(i) : DATA_WIDTH'(vval);
    end
  endtask

  // kind 0: start then vec_valid; kind 2: start and vec_valid together, later capture.
  task automatic launch(input int kind);
    ov_base   = ov_cnt;
    rd_base   = rd_cnt;
    done_base = done_cnt;
    err_base  = addr_err;
    @(negedge clk);
    bus.start_signal = 1'b1;
    bus.vec_valid    = (kind == 2);
    @(negedge clk);
    bus.start_signal = 1'b0;
    bus.vec_valid    = 1'b0;
    if (kind == 2) begin
      repeat (3) @(negedge clk);
      check("samecyc_no_capture_rd_en", bus.weight_rd_en, 0);
      check("samecyc_waiting_busy", bus.busy, 1);
    end
    bus.vec_valid = 1'b1;
    @(negedge clk);
    bus.vec_valid = 1'b0;
    cap_cyc = cyc;
    set_vec(1'b0, 12345);  // later vec_in changes must not matter
  endtask

  task automatic finish_run(input string name, input bit eramp, input int econst,
                            input bit mid_start);
    int c;
    if (mid_start) begin
      repeat (300) @(negedge clk);
      bus.start_signal = 1'b1;
      @(negedge clk);
      bus.start_signal = 1'b0;
    end
    c = 0;
    while (c < 3000 && done_cnt == done_base) begin
      @(negedge clk);
      c++;
    end
    if (done_cnt == done_base) check({name, "_done_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
    check({name, "_out_valid_count"}, ov_cnt - ov_base, 10);
    for (int k = 0; k < 10; k++) begin
      check({name, "_idx"}, ov_idx[ov_base + k], k);
      check({name, "_data"}, ov_data[ov_base + k], eramp ? ramp_exp[k] : econst);
      check({name, "_emit_cycle"}, ov_cyc[ov_base + k] - cap_cyc, 226 + 227 * k);
    end
    check({name, "_done_count"}, done_cnt - done_base, 1);
    check({name, "_done_after_last"}, done_cyc - ov_cyc[ov_base + 9], 1);
    check({name, "_rd_en_cycles"}, rd_cnt - rd_base, 2250);
    check({name, "_addr_contiguous_errs"}, addr_err - err_base, 0);
    check({name, "_idle_busy"}, bus.busy, 0);
    check({name, "_idle_rd_en"}, bus.weight_rd_en, 0);
    check({name, "_addr_hold"}, bus.weight_addr, 2249);
  endtask

  vec_t tbl[6];

  initial begin
    int c;
    int snap_ov, snap_done;

    tbl[0] = '{"ones",   1'b0, 64,      1'b0, 64,   1'b0, 14400};
    tbl[1] = '{"ramp",   1'b1, 0,       1'b1, 0,    1'b1, 0};
    tbl[2] = '{"satpos", 1'b0, 2097151, 1'b0, 127,  1'b0, 2097151};
    tbl[3] = '{"satneg", 1'b0, 2097151, 1'b0, -128, 1'b0, -2097152};
    tbl[4] = '{"floor",  1'b0, -1,      1'b0, 1,    1'b0, -4};
    tbl[5] = '{"negw",   1'b0, 64,      1'b0, -64,  1'b0, -14400};

    bus.start_signal = 1'b0;
    bus.vec_valid    = 1'b0;
    set_vec(1'b0, 0);

    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_en", bus.weight_rd_en, 0);
    check("rst_addr", bus.weight_addr, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_done", bus.done_signal, 0);
    rst = 1'b1;

    // vec_valid alone in IDLE does nothing.
    @(negedge clk);
    bus.vec_valid = 1'b1;
    @(negedge clk);
    bus.vec_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_vec_valid_ignored", bus.busy, 0);

    for (int t = 0; t < 6; t++) begin
      set_vec(tbl[t].vramp, tbl[t].vval);
      w_ramp = tbl[t].wramp;
      w_val  = tbl[t].wval;
      launch(0);
      finish_run(tbl[t].name, tbl[t].eramp, tbl[t].econst, 1'b0);
    end

    // start pulsed mid-RUN is ignored.
    set_vec(1'b0, 64);
    w_ramp = 1'b0;
    w_val  = 64;
    launch(0);
    finish_run("midstart", 1'b0, 14400, 1'b1);

    // start and vec_valid in the same IDLE cycle: capture only on a later vec_valid.
    set_vec(1'b1, 0);
    w_ramp = 1'b1;
    launch(2);
    finish_run("samecyc", 1'b1, 0, 1'b0);

    // Reset at neuron 4, j=100 (address 1000).
    set_vec(1'b1, 0);
    w_ramp = 1'b1;
    launch(0);
    c = 0;
    while (c < 3000 && !(bus.weight_rd_en && bus.weight_addr == 12'd1000)) begin
      @(negedge clk);
      c++;
    end
    check("abort_reached_addr_1000", bus.weight_addr, 1000);
    #2;
    rst = 1'b0;
    #1;
    check("abort_rd_en", bus.weight_rd_en, 0);
    check("abort_addr", bus.weight_addr, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_idx", bus.out_idx, 0);
    check("abort_out_data", bus.out_data, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done_signal, 0);
    repeat (3) @(negedge clk);
    snap_ov   = ov_cnt;
    snap_done = done_cnt;
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("abort_no_out_valid", ov_cnt - snap_ov, 0);
    check("abort_no_done", done_cnt - snap_done, 0);
    check("abort_stays_idle", bus.busy, 0);

    set_vec(1'b1, 0);
    launch(0);
    finish_run("recover", 1'b1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
